uart_rx_word_packer: RTL and testbench
======================================

# uart_rx_word_packer

Sits between the UART receiver and the RX FIFO. It packs received bytes into `BYTES_PER_WORD`-byte words, little-endian, and writes each completed word to the FIFO. If the line goes idle mid-word, it flushes the partial word after a configurable timeout, with a per-byte valid mask. Bytes that cannot be held while the FIFO is full are counted, not silently lost.

## Interface
Parameters:
- `BYTES_PER_WORD`, default 4: bytes per FIFO word; legal range 1..16.
- `TIMEOUT_CYCLES`, default 1024: idle clocks before a partial word is flushed; 0 disables flushing.
- `CNT_W`, default 16: width of the dropped-byte counter.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `data_byte` in 8: received byte; valid while `data_avail` = 1.
- `data_avail` in 1: one-cycle strobe, one per received byte.
- `full` in 1: FIFO full flag; must already account for one in-flight write.
- `clear_drops` in 1: synchronous clear of `drop_cnt`.
- `wr_en` out 1: FIFO write strobe, one cycle per word.
- `din` out 8*BPW: packed word; byte i is at bits [8i+7:8i].
- `din_mask` out BPW: bit i = 1 means byte lane i is valid.
- `drop_cnt` out CNT_W: saturating count of dropped bytes.
- `overflow` out 1: sticky; set on the first drop, cleared by `clear_drops`.

## Operation
- Internal state:
  - accumulation buffer `acc` (8*BPW bits);
  - lane index `idx`, 0..BPW-1;
  - idle counter;
  - FSM with states FILL and HOLD.
- FILL, on `data_avail`:
  - write `acc` lane `idx` = `data_byte`;
  - if `idx` = BPW-1: go to HOLD with mask all-ones;
  - otherwise `idx` increments.
- Idle counter:
  - counts cycles in FILL with `idx` > 0 and `data_avail` = 0;
  - resets to 0 on any `data_avail`.
- Timeout: when the idle counter reaches `TIMEOUT_CYCLES` (nonzero), go to HOLD with mask = lanes 0..idx-1.
- With `idx` = 0 there is never a timeout or flush; empty words are never written.
- HOLD with `full` = 0, in one edge:
  - `din` <= `acc`, with invalid lanes forced to 0x00;
  - `din_mask` <= mask, `wr_en` <= 1;
  - `acc` <= 0, `idx` <= 0, go to FILL.
- HOLD with `full` = 0 and `data_avail` in the same cycle: the byte goes into lane 0 of the new word and `idx` = 1. The byte is not lost.
  - If BPW = 1, that byte fills the new word and the FSM stays in HOLD.
- HOLD with `full` = 1:
  - stay in HOLD;
  - `data_avail` in this state drops the byte: `drop_cnt` +1, saturating at 2^CNT_W-1; `overflow` <= 1.
- `clear_drops` wins over a simultaneous increment: the counter is 0 afterwards.
- `wr_en` is high for exactly one cycle per write; it is never high on two consecutive edges unless BPW = 1.

## Timing
- Reset values (async, immediate on `rst_n` low):
  - `wr_en` = 0, `din` = 0, `din_mask` = 0, `drop_cnt` = 0, `overflow` = 0;
  - FSM = FILL, `idx` = 0, `acc` = 0, idle counter = 0.
- Reset mid-word: the partial word is discarded and no write is issued.
- Full-word latency: final byte sampled at edge E0 puts the FSM in HOLD. If `full` is low at E1, `wr_en` is high in the cycle after E1, i.e. 2 clocks after the `data_avail` cycle.
- Flush latency: the timeout fires at the edge where the idle counter reaches `TIMEOUT_CYCLES`. `wr_en` follows one edge later if `full` is low.
- `full` is sampled one edge before `wr_en` rises. Back-to-back writes are impossible for BPW ≥ 2, since filling a word takes at least 2 strobes.
- `drop_cnt` and `overflow` update on the edge that samples the dropped strobe.

## Test plan
- Basic packing:
  - stimulus: BPW = 4; bytes 0x11, 0x22, 0x33, 0x44 one per 3 cycles, `full` = 0;
  - required: exactly one `wr_en` pulse 2 cycles after 0x44, with `din` = 0x44332211 and `din_mask` = 4'b1111.
- Partial flush:
  - stimulus: BPW = 4, TIMEOUT = 8; bytes 0xAA, 0xBB, then idle;
  - required: `din` = 0x0000BBAA and `din_mask` = 4'b0011, written 9 cycles after 0xBB; no write with timeout disabled (TIMEOUT = 0).
- Full backpressure:
  - stimulus: complete a word with `full` = 1, send 3 more bytes, then release `full`;
  - required: `drop_cnt` = 3, `overflow` = 1, and one write of the original word after release.
- Simultaneous write and byte:
  - stimulus: a byte arrives in the HOLD cycle where `full` goes low;
  - required: the previous word is written and the new byte appears in lane 0 of the next word.
- Counter behaviour:
  - stimulus: CNT_W = 2 with 5 drops, then `clear_drops` pulsed coincident with a drop;
  - required: the count saturates at 3, then reads 0.
- Reset:
  - stimulus: assert `rst_n` low after 2 bytes of a word, with no clock edge during reset;
  - required: outputs are at reset values immediately; after release, 4 new bytes produce a clean word containing no stale data.

Source files
------------

// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer
//   Packs bytes from the UART receiver into BYTES_PER_WORD-byte little-endian
//   words and writes each word to the RX FIFO. A partial word is flushed with
//   a per-lane valid mask after TIMEOUT_CYCLES idle clocks (0 = never flush).
//   Bytes arriving while a completed word waits on a full FIFO are dropped and
//   counted in a saturating counter, with a sticky overflow flag.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_byte    received byte, qualified by data_avail
//   data_avail   one-cycle strobe per received byte
//   full         FIFO full (already accounts for one in-flight write)
//   clear_drops  synchronous clear of drop_cnt and overflow
//   wr_en        FIFO write strobe, one cycle per word
//   din          packed word, byte i at [8i+7:8i]; invalid lanes are 0x00
//   din_mask     per-lane valid mask for din
//   drop_cnt     saturating count of dropped bytes
//   overflow     sticky, set on the first drop
module uart_rx_word_packer #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  data_byte,
  input  logic                        data_avail,
  input  logic                        full,
  input  logic                        clear_drops,
  output logic                        wr_en,
  output logic [8*BYTES_PER_WORD-1:0] din,
  output logic [BYTES_PER_WORD-1:0]   din_mask,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic                        overflow
);

  localparam int unsigned BPW   = BYTES_PER_WORD;
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t               r_state, w_state_nxt;
  logic [8*BPW-1:0]     r_acc, w_acc_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [TO_W-1:0]      r_idle, w_idle_nxt;
  logic [BPW-1:0]       r_mask, w_mask_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic [8*BPW-1:0]     r_din, w_din_nxt;
  logic [BPW-1:0]       r_din_mask, w_din_mask_nxt;
  logic [CNT_W-1:0]     r_drop_cnt;
  logic                 r_overflow;
  logic                 w_drop;
  logic [BPW-1:0]       w_part_mask;
  logic [8*BPW-1:0]     w_lane_bits;

  // Lanes below the current index are the ones filled so far; the held mask
  // expanded to bit level zeroes unused lanes on write.
  always_comb begin
    w_part_mask = '0;
    w_lane_bits = '0;
    for (int unsigned i = 0; i < BPW; i++) begin
      w_part_mask[i]         = (IDX_W'(i) < r_idx);
      w_lane_bits[8*i +: 8]  = {8{r_mask[i]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_idx_nxt      = r_idx;
    w_idle_nxt     = '0;
    w_mask_nxt     = r_mask;
    w_wr_en_nxt    = 1'b0;
    w_din_nxt      = r_din;
    w_din_mask_nxt = r_din_mask;
    w_drop         = 1'b0;
    case (r_state)
      FILL: begin
        if (data_avail) begin
          for (int unsigned i = 0; i < BPW; i++) begin
            if (IDX_W'(i) == r_idx) w_acc_nxt[8*i +: 8] = data_byte;
          end
          if (r_idx == IDX_W'(BPW - 1)) begin
            w_state_nxt = HOLD;
            w_mask_nxt  = '1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else if (TIMEOUT_CYCLES != 0 && r_idx != '0) begin
          w_idle_nxt = r_idle + TO_W'(1);
          if (w_idle_nxt == TO_W'(TIMEOUT_CYCLES)) begin
            w_state_nxt = HOLD;
            w_mask_nxt  = w_part_mask;
            w_idle_nxt  = '0;
          end
        end
      end
      HOLD: begin
        if (!full) begin
          w_wr_en_nxt    = 1'b1;
          w_din_nxt      = r_acc & w_lane_bits;
          w_din_mask_nxt = r_mask;
          w_acc_nxt      = '0;
          w_idx_nxt      = '0;
          w_state_nxt    = FILL;
          // A byte arriving on the write edge starts the next word in lane 0.
          if (data_avail) begin
            w_acc_nxt[7:0] = data_byte;
            if (BPW == 1) begin
              w_state_nxt = HOLD;
              w_mask_nxt  = '1;
            end else begin
              w_idx_nxt = IDX_W'(1);
            end
          end
        end else if (data_avail) begin
          w_drop = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_idx      <= '0;
      r_idle     <= '0;
      r_mask     <= '0;
      r_wr_en    <= 1'b0;
      r_din      <= '0;
      r_din_mask <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_acc      <= w_acc_nxt;
      r_idx      <= w_idx_nxt;
      r_idle     <= w_idle_nxt;
      r_mask     <= w_mask_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_din      <= w_din_nxt;
      r_din_mask <= w_din_mask_nxt;
      // Clear takes priority over a drop on the same edge.
      if (clear_drops) begin
        r_drop_cnt <= '0;
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        r_overflow <= 1'b1;
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign din      = r_din;
  assign din_mask = r_din_mask;
  assign drop_cnt = r_drop_cnt;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Scoreboard bench for uart_rx_word_packer. Instance A: BPW=4, TIMEOUT=8,
// CNT_W=2. Instance B: BPW=4, TIMEOUT=0, fed only during the partial-word
// test; it must never write.
module tb_uart_rx_word_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_byte;
  logic        data_avail;
  logic        full;
  logic        clear_drops;
  logic        en_b;
  logic        data_avail_b;

  logic        wr_en_a, wr_en_b;
  logic [31:0] din_a, din_b;
  logic [3:0]  mask_a, mask_b;
  logic [1:0]  drop_a;
  logic [15:0] drop_b;
  logic        ovf_a, ovf_b;

  assign data_avail_b = data_avail & en_b;

  uart_rx_word_packer #(
    .BYTES_PER_WORD(4), .TIMEOUT_CYCLES(8), .CNT_W(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .data_byte(data_byte), .data_avail(data_avail),
    .full(full), .clear_drops(clear_drops), .wr_en(wr_en_a), .din(din_a),
    .din_mask(mask_a), .drop_cnt(drop_a), .overflow(ovf_a)
  );

  uart_rx_word_packer #(
    .BYTES_PER_WORD(4), .TIMEOUT_CYCLES(0), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .data_byte(data_byte), .data_avail(data_avail_b),
    .full(1'b0), .clear_drops(1'b0), .wr_en(wr_en_b), .din(din_b),
    .din_mask(mask_b), .drop_cnt(drop_b), .overflow(ovf_b)
  );

  typedef struct {
    logic [31:0] din;
    logic [3:0]  mask;
    int unsigned edge_no;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned edge_n   = 0;
  int unsigned b_writes = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every write from instance A must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en_a) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL write_unexpected: got din=%h mask=%b at edge %0d, expected no write",
                 din_a, mask_a, edge_n);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (din_a === e.din && mask_a === e.mask && edge_n == e.edge_no) n_pass++;
        else $display("FAIL write: got din=%h mask=%b edge=%0d, expected din=%h mask=%b edge=%0d",
                      din_a, mask_a, edge_n, e.din, e.mask, e.edge_no);
      end
    end
    if (wr_en_b) b_writes++;
  end

  task automatic push(input logic [31:0] d, input logic [3:0] m, input int unsigned e);
    exp_t x;
    x.din = d; x.mask = m; x.edge_no = e;
    sb.push_back(x);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    data_byte  = b;
    data_avail = 1'b1;
    @(posedge clk); #1;
    data_avail = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; data_byte = '0; data_avail = 1'b0; full = 1'b0;
    clear_drops = 1'b0; en_b = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_wr_en", 32'(wr_en_a), 32'd0);
    check("rst_din", din_a, 32'd0);
    check("rst_mask", 32'(mask_a), 32'd0);
    check("rst_drop", 32'(drop_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic packing, one byte every 3 cycles.
    send(8'h11); idle(2); send(8'h22); idle(2); send(8'h33); idle(2); send(8'h44);
    push(32'h44332211, 4'b1111, edge_n + 1);
    idle(4);

    // Partial flush; instance B (timeout disabled) sees the same bytes.
    en_b = 1'b1;
    send(8'hAA); idle(2); send(8'hBB);
    push(32'h0000BBAA, 4'b0011, edge_n + 9);
    en_b = 1'b0;
    idle(15);

    // Backpressure: word completes with full high, then 3 drops.
    full = 1'b1;
    send(8'h01); idle(1); send(8'h02); idle(1); send(8'h03); idle(1); send(8'h04);
    send(8'hE1);
    check("drop_first", 32'(drop_a), 32'd1);
    check("ovf_first", 32'(ovf_a), 32'd1);
    send(8'hE2); send(8'hE3);
    check("drop_three", 32'(drop_a), 32'd3);
    check("ovf_three", 32'(ovf_a), 32'd1);
    push(32'h04030201, 4'b1111, edge_n + 1);
    full = 1'b0;
    idle(3);
    clear_drops = 1'b1; idle(1); clear_drops = 1'b0;
    check("drop_cleared", 32'(drop_a), 32'd0);
    check("ovf_cleared", 32'(ovf_a), 32'd0);

    // Byte arrives on the same cycle full releases.
    full = 1'b1;
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    push(32'h40302010, 4'b1111, edge_n + 1);
    full = 1'b0;
    send(8'h50);
    send(8'h60); idle(1); send(8'h70); idle(1); send(8'h80);
    push(32'h80706050, 4'b1111, edge_n + 1);
    idle(3);
    check("drop_none", 32'(drop_a), 32'd0);

    // Saturation at 3 with CNT_W=2, then clear coincident with a drop.
    full = 1'b1;
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    for (int unsigned i = 0; i < 5; i++) send(8'hF0);
    check("drop_sat", 32'(drop_a), 32'd3);
    check("ovf_sat", 32'(ovf_a), 32'd1);
    clear_drops = 1'b1;
    send(8'hFF);
    clear_drops = 1'b0;
    check("drop_clear_wins", 32'(drop_a), 32'd0);
    push(32'hA4A3A2A1, 4'b1111, edge_n + 1);
    full = 1'b0;
    idle(3);

    // Make outputs nonzero before the reset test.
    full = 1'b1;
    send(8'hD1); send(8'hD2); send(8'hD3); send(8'hD4);
    send(8'hEE);
    check("drop_pre_rst", 32'(drop_a), 32'd1);
    push(32'hD4D3D2D1, 4'b1111, edge_n + 1);
    full = 1'b0;
    idle(3);
    send(8'hC1); send(8'hC2);

    // Asynchronous reset mid-word, no clock edge while asserted.
    rst_n = 1'b0;
    #2;
    check("rst2_wr_en", 32'(wr_en_a), 32'd0);
    check("rst2_din", din_a, 32'd0);
    check("rst2_mask", 32'(mask_a), 32'd0);
    check("rst2_drop", 32'(drop_a), 32'd0);
    check("rst2_ovf", 32'(ovf_a), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    push(32'h08070605, 4'b1111, edge_n + 1);
    idle(20);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("b_no_write", 32'(b_writes), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
